// File: rtl/ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module : ctrl_pipe_chain
// Desc   : N-stage control-word pipeline (execute..writeback) with per-stage
//          valid/stall/flush, backward hold and retire/bubble counters.
// Rev    : 1.0 - initial release
// ============================================================================
module ctrl_pipe_chain #(
    parameter int               WIDTH      = 32,
    parameter int               STAGES     = 3,
    parameter logic [WIDTH-1:0] RESET_WORD = {WIDTH{1'b0}},
    parameter int               CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_word,
    output logic                    in_ready,
    input  logic [STAGES-1:0]       stall_i,
    input  logic [STAGES-1:0]       flush_i,
    input  logic                    flush_all,
    output logic [STAGES-1:0]       hold_o,
    output logic [STAGES-1:0]       valid_o,
    output logic [STAGES*WIDTH-1:0] word_o,
    input  logic                    clr_cnt,
    output logic [CNT_W-1:0]        retire_cnt,
    output logic [CNT_W-1:0]        bubble_cnt
);

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_clear;
    logic [STAGES-1:0] w_bubble;
    logic [STAGES-1:0] w_next_valid;
    logic [WIDTH-1:0]  w_next_word [STAGES];
    logic [CNT_W-1:0]  w_bubble_sum;
    logic              w_retire;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_word [STAGES];
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // A stalled stage holds everything upstream of it; flush never affects hold.
    always_comb begin
        w_hold           = '0;
        w_hold[STAGES-1] = stall_i[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_hold[k] = stall_i[k] | w_hold[k + 1];
        end
    end

    assign w_clear = {STAGES{flush_all}} | flush_i;

    always_comb begin
        w_next_valid = r_valid;
        w_next_word  = r_word;
        w_bubble     = '0;

        if (!w_hold[0]) begin
            w_next_valid[0] = in_valid;
            w_next_word[0]  = in_valid ? in_word : RESET_WORD;
        end

        for (int k = 1; k < STAGES; k++) begin
            if (!w_hold[k]) begin
                if (w_hold[k - 1]) begin
                    w_next_valid[k] = 1'b0;
                    w_next_word[k]  = RESET_WORD;
                    w_bubble[k]     = !w_clear[k];
                end else begin
                    w_next_valid[k] = r_valid[k - 1];
                    w_next_word[k]  = r_word[k - 1];
                end
            end
        end

        // Flush wins over both hold and load.
        for (int k = 0; k < STAGES; k++) begin
            if (w_clear[k]) begin
                w_next_valid[k] = 1'b0;
                w_next_word[k]  = RESET_WORD;
            end
        end
    end

    always_comb begin
        w_bubble_sum = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_bubble_sum = w_bubble_sum + CNT_W'(w_bubble[k]);
        end
    end

    assign w_retire = r_valid[STAGES-1] & ~w_hold[STAGES-1] & ~w_clear[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_word[k] <= RESET_WORD;
            end
        end else begin
            r_valid <= w_next_valid;
            r_word  <= w_next_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else if (clr_cnt) begin
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(w_retire);
            r_bubble_cnt <= r_bubble_cnt + w_bubble_sum;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign word_o[g*WIDTH +: WIDTH] = r_word[g];
    end

    assign in_ready   = ~w_hold[0];
    assign hold_o     = w_hold;
    assign valid_o    = r_valid;
    assign retire_cnt = r_retire_cnt;
    assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_chain.sv
`default_nettype none
// ============================================================================
// Module : tb_ctrl_pipe_chain
// Desc   : Directed bench for ctrl_pipe_chain (WIDTH=8, STAGES=3) with a
//          retirement scoreboard and a 4-bit-counter instance for wrap.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_chain;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_word;
    logic [2:0]  stall_i;
    logic [2:0]  flush_i;
    logic        flush_all;
    logic        clr_cnt;

    logic        in_ready,  in_ready4;
    logic [2:0]  hold_o,    hold_o4;
    logic [2:0]  valid_o,   valid_o4;
    logic [23:0] word_o,    word_o4;
    logic [31:0] retire_cnt, bubble_cnt;
    logic [3:0]  retire_cnt4, bubble_cnt4;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb_q [$];
    logic [7:0]  sb_exp;
    logic        sb_on = 1'b0;

    ctrl_pipe_chain #(.WIDTH(8), .STAGES(3), .RESET_WORD(8'h00), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .stall_i(stall_i), .flush_i(flush_i),
        .flush_all(flush_all), .hold_o(hold_o), .valid_o(valid_o),
        .word_o(word_o), .clr_cnt(clr_cnt), .retire_cnt(retire_cnt),
        .bubble_cnt(bubble_cnt)
    );

    ctrl_pipe_chain #(.WIDTH(8), .STAGES(3), .RESET_WORD(8'h00), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready4), .stall_i(stall_i), .flush_i(flush_i),
        .flush_all(flush_all), .hold_o(hold_o4), .valid_o(valid_o4),
        .word_o(word_o4), .clr_cnt(clr_cnt), .retire_cnt(retire_cnt4),
        .bubble_cnt(bubble_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pipe(input string tag, input logic [2:0] v, input logic [23:0] w);
        chk({tag, "_valid"}, 32'(valid_o), 32'(v));
        chk({tag, "_word"},  32'(word_o),  32'(w));
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] r, input logic [31:0] b);
        chk({tag, "_retire"}, retire_cnt, r);
        chk({tag, "_bubble"}, bubble_cnt, b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] w, input logic push);
        in_valid = v;
        in_word  = w;
        if (push) sb_q.push_back(w);
    endtask

    // Retirement monitor: the stage-2 word leaving at the next edge must be the oldest pushed word.
    always @(negedge clk) begin
        if (sb_on && !rst && valid_o[2] && !stall_i[2] && !flush_all && !flush_i[2]) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", 32'(word_o[23:16]), 32'hFFFF_FFFF);
            end else begin
                sb_exp = sb_q.pop_front();
                chk("sb_retire", 32'(word_o[23:16]), 32'(sb_exp));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 8'h00;
        stall_i   = 3'b101;
        flush_i   = 3'b000;
        flush_all = 1'b0;
        clr_cnt   = 1'b0;

        // hold/in_ready are combinational from stall even in reset
        #2;
        chk("rst_hold", 32'(hold_o), 32'(3'b111));
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        stall_i = 3'b000;
        #1;
        chk("rst_in_ready_free", 32'(in_ready), 32'd1);
        chk_pipe("rst_state", 3'b000, 24'h000000);
        chk_cnt("rst_cnt", 32'd0, 32'd0);

        // Fill / drain
        tick();
        rst   = 1'b0;
        sb_on = 1'b1;
        drive(1'b1, 8'h11, 1'b1); tick();
        drive(1'b1, 8'h22, 1'b1); tick();
        drive(1'b1, 8'h33, 1'b1); tick();
        chk_pipe("fill_e3", 3'b111, 24'h112233);
        drive(1'b0, 8'h00, 1'b0); tick();
        chk_pipe("drain_e4", 3'b110, 24'h223300);
        tick();
        chk_pipe("drain_e5", 3'b100, 24'h330000);
        tick();
        chk_pipe("drain_e6", 3'b000, 24'h000000);
        chk_cnt("drain_cnt", 32'd3, 32'd0);

        // Stall insertion on stage 0
        drive(1'b1, 8'hA5, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        stall_i = 3'b001;
        #1;
        chk("stall0_in_ready", 32'(in_ready), 32'd0);
        chk("stall0_hold", 32'(hold_o), 32'(3'b001));
        tick();
        chk_pipe("stall0_c1", 3'b001, 24'h0000A5);
        chk_cnt("stall0_c1_cnt", 32'd3, 32'd1);
        tick();
        chk_pipe("stall0_c2", 3'b001, 24'h0000A5);
        chk_cnt("stall0_c2_cnt", 32'd3, 32'd2);
        stall_i = 3'b000;
        tick();
        chk_pipe("stall0_release", 3'b010, 24'h00A500);
        tick();
        tick();
        chk_cnt("stall0_retire", 32'd4, 32'd2);
        sb_on = 1'b0;
        chk("sb_empty_1", 32'(sb_q.size()), 32'd0);

        // Backward hold propagation
        drive(1'b1, 8'hB1, 1'b0); tick();
        drive(1'b1, 8'hB2, 1'b0); tick();
        chk_pipe("bp_load", 3'b011, 24'h00B1B2);
        drive(1'b1, 8'hCC, 1'b0);
        stall_i = 3'b100;
        #1;
        chk("bp_hold", 32'(hold_o), 32'(3'b111));
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk_pipe("bp_frozen", 3'b011, 24'h00B1B2);
        chk_cnt("bp_cnt", 32'd4, 32'd2);

        // Flush overrides hold; stage 2 gets a bubble
        drive(1'b0, 8'h00, 1'b0);
        stall_i = 3'b011;
        flush_i = 3'b010;
        #1;
        chk("fh_hold", 32'(hold_o), 32'(3'b011));
        tick();
        chk_pipe("fh_state", 3'b001, 24'h0000B2);
        chk_cnt("fh_cnt", 32'd4, 32'd3);
        stall_i = 3'b000;
        flush_i = 3'b000;

        // Exception flush with full pipe and everything stalled
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        chk_pipe("exc_full", 3'b111, 24'h112233);
        chk_cnt("exc_full_cnt", 32'd5, 32'd3);
        drive(1'b1, 8'h44, 1'b0);
        stall_i   = 3'b111;
        flush_all = 1'b1;
        #1;
        chk("exc_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk_pipe("exc_flushed", 3'b000, 24'h000000);
        chk_cnt("exc_cnt", 32'd5, 32'd3);
        stall_i   = 3'b000;
        flush_all = 1'b0;

        // Mid-cycle asynchronous reset
        drive(1'b1, 8'h55, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0); tick();
        chk_pipe("arst_pre", 3'b010, 24'h005500);
        #2;
        rst = 1'b1;
        #1;
        chk_pipe("arst_now", 3'b000, 24'h000000);
        chk_cnt("arst_cnt", 32'd0, 32'd0);
        chk("arst_cnt4", 32'(retire_cnt4), 32'd0);
        tick();
        rst = 1'b0;

        // Counter clear beats a same-cycle retire
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b1, 8'h66, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0); tick();
        chk_pipe("clr_pre", 3'b110, 24'h776600);
        tick();
        chk_cnt("clr_one_retire", 32'd1, 32'd0);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk_cnt("clr_applied", 32'd0, 32'd0);
        chk_pipe("clr_empty", 3'b000, 24'h000000);

        // Full-rate stream through the scoreboard; 4-bit counter wraps at 16
        sb_on = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i * 7 + 3), 1'b1);
            tick();
            if (i == 18) begin
                chk("wrap_cnt32", retire_cnt, 32'd16);
                chk("wrap_cnt4", 32'(retire_cnt4), 32'd0);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        tick();
        tick();
        chk_cnt("stream_cnt", 32'd20, 32'd0);
        chk("stream_cnt4", 32'(retire_cnt4), 32'd4);
        chk("stream_bub4", 32'(bubble_cnt4), 32'd0);
        chk("stream_valid4", 32'(valid_o4), 32'd0);
        chk("stream_word4", 32'(word_o4), 32'd0);
        chk("stream_ready4", 32'(in_ready4), 32'd1);
        chk("stream_hold4", 32'(hold_o4), 32'd0);
        chk_pipe("stream_empty", 3'b000, 24'h000000);
        chk("sb_empty_2", 32'(sb_q.size()), 32'd0);
        sb_on = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe_chain.md
# ctrl_pipe_chain

Parametrised N-stage control-word pipeline carrying decoded control bits from the decode stage through execute, memory and writeback. Every stage has its own valid bit, stall and flush. Stall propagates backwards automatically. A bubble is inserted wherever a stalled stage is followed by a moving one. The block also keeps retire and bubble counters for performance monitoring. It replaces the fixed-width, fixed-depth E/M/W control registers in the CPU controller; one instance serves any stage count and control-word width.

## Interface
Parameters:
- WIDTH, 32: control-word width in bits.
- STAGES, 3: number of pipeline stages (≥2). Stage 0 = execute, stage STAGES-1 = writeback.
- RESET_WORD, {WIDTH{1'b0}}: word held by empty, flushed or reset stages.
- CNT_W, 32: width of the performance counters.

Ports (clk and rst: one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  decode stage presents a valid control word.
- in_word  in  WIDTH  decoded control word.
- in_ready  out  1  stage 0 accepts this cycle; combinational, equals ~hold[0].
- stall_i  in  STAGES  per-stage stall request; bit k is stage k.
- flush_i  in  STAGES  per-stage flush request.
- flush_all  in  1  exception flush; clears every stage.
- hold_o  out  STAGES  effective per-stage hold; combinational.
- valid_o  out  STAGES  per-stage valid, registered.
- word_o  out  STAGES*WIDTH  per-stage word, registered; stage k occupies bits [k*WIDTH +: WIDTH].
- clr_cnt  in  1  synchronous clear of both counters.
- retire_cnt  out  CNT_W  number of valid words that left the last stage.
- bubble_cnt  out  CNT_W  number of internal bubbles inserted.

## Operation
- Hold propagation:
  - hold[STAGES-1] = stall_i[STAGES-1].
  - hold[k] = stall_i[k] | hold[k+1] for k < STAGES-1.
- Per-stage update at each edge, highest priority first:
  - flush_all: valid 0, word RESET_WORD.
  - flush_i[k]: valid 0, word RESET_WORD. Flush overrides hold.
  - hold[k]: keep current contents.
  - Stage 0 load: takes in_word with valid 1 if in_valid, else RESET_WORD with valid 0.
  - Stage k≥1 load when hold[k-1]=1 (upstream stalled, stage k moving): bubble, valid 0, word RESET_WORD.
  - Stage k≥1 load otherwise: takes stage k-1 word and valid.
- A bubble loaded into a stage always carries RESET_WORD, even when the upstream stage holds a valid word.
- retire_cnt increments by 1 when valid_o[STAGES-1]=1, hold[STAGES-1]=0, flush_all=0 and flush_i[STAGES-1]=0.
- bubble_cnt increments by the number of stages k≥1 that load a bubble this cycle. A stage that is also flushed that cycle is not counted.
- Counters wrap modulo 2^CNT_W.
- clr_cnt forces both counters to 0 and overrides any same-cycle increment.
- Reset clears all valid bits to 0, all words to RESET_WORD and both counters to 0. Reset takes effect immediately, mid-cycle included.
- in_ready and hold_o are defined during reset; they depend only on stall_i.

## Timing
- Latency: a word accepted at edge t (in_ready=1) is on stage 0 after edge t. With no holds it reaches stage k after edge t+k.
- Throughput: one word per cycle with no stalls.
- in_ready, hold_o: combinational from stall_i only. No path from in_valid, in_word or the flush inputs.
- valid_o, word_o, counters: registered only.
- Simultaneous stall_i[k] and flush_i[k]: stage k clears. Stages below k still hold, because hold is independent of flush.
- flush_i on an empty stage: no counter change.
- stall_i all ones: whole pipe frozen, in_ready=0, no counter increments.

## Test plan
All scenarios use WIDTH=8, STAGES=3, RESET_WORD=0.
- Fill/drain: release rst, drive in_word 0x11, 0x22, 0x33 valid on 3 consecutive cycles, then in_valid=0 -> stage 2 shows 0x11/0x22/0x33 after edges 3/4/5; retire_cnt = 3 two cycles later.
- Stall insertion: stage 0 holds 0xA5, stall_i=3'b001 for 2 cycles -> in_ready=0; stage 0 stays 0xA5; stage 1 valid 0, word 0x00 for 2 cycles; bubble_cnt +2; 0xA5 reaches stage 1 one edge after the stall drops.
- Backward propagation: stall_i=3'b100 -> hold_o=3'b111, in_ready=0; all stages and both counters unchanged.
- Flush vs hold: stall_i=3'b011, flush_i=3'b010 -> stage 1 cleared (valid 0, word 0x00); stage 0 keeps its word; stage 2 loads a bubble and bubble_cnt +1.
- Exception and reset: stages full (0x11/0x22/0x33), flush_all=1 with stall_i=3'b111 -> all valid 0 after the edge. Separately, assert rst between edges -> valid_o, word_o and counters read 0 before the next edge.
- Counter clear: clr_cnt=1 in the same cycle as a retire -> retire_cnt=0 next cycle. Separately, CNT_W=4 with 16 retires -> retire_cnt wraps to 0.
